// File: rtl/alu_pipe_md_if.sv
// ALU request/response bundle: operands and op in, registered result and HI/LO out.
// Latency: none (pure wiring between requester and ALU).
// Backpressure: in_ready low while a multi-cycle op is in flight; requests are held off.
interface alu_pipe_md_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic [SHW-1:0]   sa;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    // Requester side
    modport master (
        output in_valid, op, num1, num2, sa,
        input  in_ready, out_valid, result, overflow, zero, hi, lo, busy
    );

    // ALU side
    modport slave (
        input  in_valid, op, num1, num2, sa,
        output in_ready, out_valid, result, overflow, zero, hi, lo, busy
    );
endinterface

// File: rtl/alu_pipe_md.sv
// MIPS-style ALU with HI/LO, iterative multiply and optional divide (macro ALU_PIPE_MD_DIV_EN).
// Latency: 1 cycle for single-cycle ops; WIDTH+2 cycles for MULT/MULTU/DIV/DIVU.
// Backpressure: in_ready = !busy; no requests accepted while a multi-cycle op runs.
module alu_pipe_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst,
    alu_pipe_md_if.slave bus
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADDU  = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SUBU  = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_OR    = 5'd5;
    localparam logic [4:0] OP_XOR   = 5'd6;
    localparam logic [4:0] OP_NOR   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_SLL   = 5'd10;
    localparam logic [4:0] OP_SRL   = 5'd11;
    localparam logic [4:0] OP_SRA   = 5'd12;
    localparam logic [4:0] OP_SLLV  = 5'd13;
    localparam logic [4:0] OP_SRLV  = 5'd14;
    localparam logic [4:0] OP_SRAV  = 5'd15;
    localparam logic [4:0] OP_MULT  = 5'd16;
    localparam logic [4:0] OP_MULTU = 5'd17;
    localparam logic [4:0] OP_MFHI  = 5'd20;
    localparam logic [4:0] OP_MFLO  = 5'd21;
    localparam logic [4:0] OP_MTHI  = 5'd22;
    localparam logic [4:0] OP_MTLO  = 5'd23;
`ifdef ALU_PIPE_MD_DIV_EN
    localparam logic [4:0] OP_DIV   = 5'd18;
    localparam logic [4:0] OP_DIVU  = 5'd19;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    logic                 busy_q;
    logic                 out_valid_q;
    logic                 overflow_q;
    logic                 zero_q;
    logic [WIDTH-1:0]     result_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic [SHW-1:0]       cnt;
    // Iteration register: {partial product, multiplier} or {remainder, quotient}
    logic [2*WIDTH-1:0]   acc;
    // Multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]     opb;
    // Negate final product / quotient
    logic                 neg_q;
`ifdef ALU_PIPE_MD_DIV_EN
    logic                 is_div;
    logic                 neg_r;
    logic                 div_zero;
    logic [WIDTH-1:0]     dividend_q;
`endif

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             accept;

    assign a      = bus.num1;
    assign b      = bus.num2;
    assign accept = bus.in_valid && !busy_q;

    assign bus.in_ready  = !busy_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

    // Single-cycle datapath: result and signed-overflow flag for the incoming op
    logic [WIDTH-1:0] sum_add;
    logic [WIDTH-1:0] sum_sub;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;

    always_comb begin
        sum_add = a + b;
        sum_sub = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
        res_c   = '0;
        ovf_c   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                res_c = sum_add;
                ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: res_c = sum_add;
            OP_SUB: begin
                res_c = sum_sub;
                ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU: res_c = sum_sub;
            OP_AND:  res_c = a & b;
            OP_OR:   res_c = a | b;
            OP_XOR:  res_c = a ^ b;
            OP_NOR:  res_c = ~(a | b);
            OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  res_c = b << bus.sa;
            OP_SRL:  res_c = b >> bus.sa;
            OP_SRA:  res_c = $unsigned($signed(b) >>> bus.sa);
            OP_SLLV: res_c = b << a[SHW-1:0];
            OP_SRLV: res_c = b >> a[SHW-1:0];
            OP_SRAV: res_c = $unsigned($signed(b) >>> a[SHW-1:0]);
            OP_MFHI: res_c = hi_q;
            OP_MFLO: res_c = lo_q;
            OP_MTHI: res_c = a;
            OP_MTLO: res_c = a;
            default: res_c = '0;
        endcase
    end

    // Operand decode for multi-cycle ops: kind, signedness and magnitudes
    logic             is_mul_in;
    logic             is_div_in;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        is_mul_in = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
`ifdef ALU_PIPE_MD_DIV_EN
        is_div_in = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
`else
        is_div_in = 1'b0;
`endif
        // Even codes (MULT, DIV) are the signed variants
        a_neg = !bus.op[0] && a[WIDTH-1];
        b_neg = !bus.op[0] && b[WIDTH-1];
        a_mag = a_neg ? ('0 - a) : a;
        b_mag = b_neg ? ('0 - b) : b;
    end

    // One radix-2 iteration step plus the final sign fix-up for HI/LO
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   mul_fin;
    logic [2*WIDTH-1:0]   step_next;
    logic [WIDTH-1:0]     fin_hi;
    logic [WIDTH-1:0]     fin_lo;
`ifdef ALU_PIPE_MD_DIV_EN
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_next;
`endif

    always_comb begin
        // Shift-add: conditionally add multiplicand to upper half, then shift right with carry
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        mul_fin   = neg_q ? ('0 - acc) : acc;
        step_next = mul_next;
        fin_hi    = mul_fin[2*WIDTH-1:WIDTH];
        fin_lo    = mul_fin[WIDTH-1:0];
`ifdef ALU_PIPE_MD_DIV_EN
        // Restoring divide: shift next dividend bit into remainder, subtract if it fits
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb};
        div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opb}) : div_shift[WIDTH-1:0];
        div_next  = {div_rem, acc[WIDTH-2:0], div_ge};
        if (is_div) begin
            step_next = div_next;
            if (div_zero) begin
                fin_lo = '1;
                fin_hi = dividend_q;
            end else begin
                fin_lo = neg_q ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
                fin_hi = neg_r ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
            end
        end
`endif
    end

    // Control FSM with registered outputs; HI/LO only change on MTHI/MTLO or in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt         <= '0;
            acc         <= '0;
            opb         <= '0;
            neg_q       <= 1'b0;
`ifdef ALU_PIPE_MD_DIV_EN
            is_div      <= 1'b0;
            neg_r       <= 1'b0;
            div_zero    <= 1'b0;
            dividend_q  <= '0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul_in || is_div_in) begin
                            state  <= S_CALC;
                            busy_q <= 1'b1;
                            cnt    <= '0;
                            neg_q  <= a_neg ^ b_neg;
`ifdef ALU_PIPE_MD_DIV_EN
                            is_div     <= is_div_in;
                            neg_r      <= a_neg;
                            div_zero   <= (b == '0);
                            dividend_q <= a;
`endif
                            if (is_div_in) begin
                                acc <= {{WIDTH{1'b0}}, a_mag};
                                opb <= b_mag;
                            end else begin
                                acc <= {{WIDTH{1'b0}}, b_mag};
                                opb <= a_mag;
                            end
                        end else begin
                            result_q    <= res_c;
                            overflow_q  <= ovf_c;
                            zero_q      <= (res_c == '0);
                            out_valid_q <= 1'b1;
                            if (bus.op == OP_MTHI) hi_q <= a;
                            if (bus.op == OP_MTLO) lo_q <= a;
                        end
                    end
                end
                S_CALC: begin
                    acc <= step_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH - 1)) state <= S_DONE;
                end
                S_DONE: begin
                    hi_q        <= fin_hi;
                    lo_q        <= fin_lo;
                    result_q    <= fin_lo;
                    overflow_q  <= 1'b0;
                    zero_q      <= (fin_lo == '0);
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state       <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe_md.sv
// Directed bench for alu_pipe_md at WIDTH=32; expected values are hand-computed constants.
// Covers single-cycle ops, HI/LO moves, iterative multiply/divide and reset abort.
module tb_alu_pipe_md;

    localparam logic [4:0] ADD = 5'd0,  ADDU = 5'd1,  SUB = 5'd2,  SUBU = 5'd3;
    localparam logic [4:0] AND_ = 5'd4, OR_ = 5'd5,   XOR_ = 5'd6, NOR_ = 5'd7;
    localparam logic [4:0] SLT = 5'd8,  SLTU = 5'd9,  SLL = 5'd10, SRL = 5'd11;
    localparam logic [4:0] SRA = 5'd12, SRLV = 5'd14, SRAV = 5'd15;
    localparam logic [4:0] MULT = 5'd16, MULTU = 5'd17, DIV = 5'd18, DIVU = 5'd19;
    localparam logic [4:0] MFHI = 5'd20, MFLO = 5'd21, MTHI = 5'd22, MTLO = 5'd23;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    alu_pipe_md_if #(.WIDTH(32)) bus ();

    alu_pipe_md #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for one cycle; returns #1 after the accepting edge
    task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] s);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.num1     = x;
        bus.num2     = y;
        bus.sa       = s;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Single-cycle op: out_valid, overflow, zero and result all checked one cycle later
    task automatic single(input string tag, input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] s,
                          input logic [31:0] exp_res, input logic exp_ovf);
        send(o, x, y, s);
        chk(tag, {bus.out_valid, bus.overflow, bus.zero, bus.result},
                 {1'b1, exp_ovf, (exp_res == 32'd0), exp_res});
    endtask

    // Multi-cycle op: scrambles operands after acceptance and waits for out_valid
    task automatic run_multi(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                             output int lat, output bit rdy_ok);
        send(o, x, y, 5'd0);
        bus.num1 = 32'hA5A5_A5A5;
        bus.num2 = 32'h5A5A_5A5A;
        lat      = 1;
        rdy_ok   = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) rdy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        bit rdy_ok;
        bit seen;

        bus.in_valid = 1'b0;
        bus.op       = 5'd0;
        bus.num1     = 32'd0;
        bus.num2     = 32'd0;
        bus.sa       = 5'd0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_flags", {bus.out_valid, bus.overflow, bus.zero, bus.busy}, 4'b0000);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", bus.in_ready, 1'b1);

        // Arithmetic and overflow
        single("add_ovf",  ADD,  32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1);
        single("addu",     ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0);
        single("sub",      SUB,  32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 1'b0);
        single("sub_ovf",  SUB,  32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b1);
        single("subu_zero", SUBU, 32'd3, 32'd3, 5'd0, 32'd0, 1'b0);

        // Logic
        single("and", AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0);
        single("or",  OR_,  32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0, 32'hFFFF_F0F0, 1'b0);
        single("xor", XOR_, 32'hFFFF_0000, 32'hFF00_FF00, 5'd0, 32'h00FF_FF00, 1'b0);
        single("nor", NOR_, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0);

        // Shifts
        single("sll",  SLL,  32'h0, 32'h1, 5'd4, 32'h0000_0010, 1'b0);
        single("srl",  SRL,  32'h0, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0);
        single("sra",  SRA,  32'h0, 32'h7F00_0000, 5'd8, 32'h007F_0000, 1'b0);
        single("srav", SRAV, 32'd4, 32'h8000_0000, 5'd0, 32'hF800_0000, 1'b0);
        single("srlv", SRLV, 32'd36, 32'h0000_00F0, 5'd0, 32'h0000_000F, 1'b0);

        // Compares, including the overflowing subtraction case
        single("slt",     SLT,  32'h8000_0000, 32'h1, 5'd0, 32'h1, 1'b0);
        single("sltu",    SLTU, 32'h8000_0000, 32'h1, 5'd0, 32'h0, 1'b0);
        single("slt_ovf", SLT,  32'h7FFF_FFFF, 32'h8000_0000, 5'd0, 32'h0, 1'b0);

        // Unused op code
        single("op24", 5'd24, 32'h1234_5678, 32'h1, 5'd0, 32'h0, 1'b0);

        // out_valid is a single-cycle pulse
        @(posedge clk);
        #1;
        chk("valid_pulse", bus.out_valid, 1'b0);

        // HI/LO moves
        single("mthi", MTHI, 32'h1234_5678, 32'h0, 5'd0, 32'h1234_5678, 1'b0);
        single("mtlo", MTLO, 32'h9ABC_DEF0, 32'h0, 5'd0, 32'h9ABC_DEF0, 1'b0);
        single("mfhi", MFHI, 32'h0, 32'h0, 5'd0, 32'h1234_5678, 1'b0);
        single("mflo", MFLO, 32'h0, 32'h0, 5'd0, 32'h9ABC_DEF0, 1'b0);

        // Signed multiply: -1 x 2
        run_multi(MULT, 32'hFFFF_FFFF, 32'h2, lat, rdy_ok);
        chk("mult_lat", lat, 34);
        chk("mult_rdy", rdy_ok, 1'b1);
        chk("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mult_res", {bus.out_valid, bus.result}, {1'b1, 32'hFFFF_FFFE});
        @(posedge clk);
        #1;
        chk("mult_after", {bus.out_valid, bus.busy, bus.in_ready}, 3'b001);
        single("mfhi_mult", MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0);

        // Unsigned multiply of the same operands
        run_multi(MULTU, 32'hFFFF_FFFF, 32'h2, lat, rdy_ok);
        chk("multu_lat", lat, 34);
        chk("multu_hilo", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);

        // Signed multiply: -3 x 5
        run_multi(MULT, 32'hFFFF_FFFD, 32'h5, lat, rdy_ok);
        chk("mult_neg_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        single("mflo_mult", MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFF1, 1'b0);

`ifdef ALU_PIPE_MD_DIV_EN
        run_multi(DIV, 32'hFFFF_FFF9, 32'h2, lat, rdy_ok);
        chk("div_lat", lat, 34);
        chk("div_rdy", rdy_ok, 1'b1);
        chk("div_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_multi(DIVU, 32'h5, 32'h0, lat, rdy_ok);
        chk("divu_zero_hilo", {bus.hi, bus.lo}, 64'h0000_0005_FFFF_FFFF);
        run_multi(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, rdy_ok);
        chk("div_min_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
`else
        // Divider absent: DIV completes in one cycle with result 0
        send(DIV, 32'd8, 32'd2, 5'd0);
        chk("div_off", {bus.out_valid, bus.busy, bus.zero, bus.result}, {3'b101, 32'h0});
        chk("div_off_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        @(posedge clk);
        #1;
        chk("div_off_busy", {bus.busy, bus.in_ready}, 2'b01);
        send(DIVU, 32'd8, 32'd2, 5'd0);
        chk("divu_off", {bus.out_valid, bus.busy, bus.result}, {2'b10, 32'h0});
`endif

        // Reset in the middle of a multiply aborts it
        send(MULT, 32'd7, 32'd9, 5'd0);
        repeat (9) @(posedge clk);
        #1;
        chk("abort_busy_pre", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("abort_flags", {bus.out_valid, bus.busy}, 2'b00);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        chk("abort_no_valid", seen, 1'b0);
        chk("abort_hilo_after", {bus.hi, bus.lo}, 64'd0);
        single("add_after_rst", ADD, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
